// File: rtl/controlador.sv
// rtl/controlador.sv - microprogrammed sequencer: 5-bit uPC over a fixed 32-word microcode ROM
//
// Ports:
//   clk                     rising-edge clock
//   rst                     asynchronous active-low reset; forces uPC to 0
//   Condicion1..Condicion6  branch conditions, sampled at the rising edge of clk
//   salida0..salida7        output code S = {salida7..salida0}, decoded from ROM[uPC]
//
// Microword layout: [15:8] output code, [7:5] sequencing select, [4:0] branch address.
//   sel = 0     : uPC + 1
//   sel = 1..6  : branch to BR when Condicion[sel] is high, otherwise hold
//   sel = 7     : unconditional branch to BR
module controlador (
    input  logic clk,
    input  logic rst,
    input  logic Condicion1,
    input  logic Condicion2,
    input  logic Condicion3,
    input  logic Condicion4,
    input  logic Condicion5,
    input  logic Condicion6,
    output logic salida0,
    output logic salida1,
    output logic salida2,
    output logic salida3,
    output logic salida4,
    output logic salida5,
    output logic salida6,
    output logic salida7
);

    logic [4:0]  upc;
    logic [4:0]  upc_next;
    logic [15:0] uword;
    logic [7:0]  s_code;
    logic [2:0]  sel;
    logic [4:0]  br;
    logic [7:0]  cond;

    // Demo program: W_k waits on Ck at 3(k-1), then A_k / B_k fall through
    // to W_(k+1). W_7 at 18 shows 0x66 and restarts on C1.
    always_comb begin
        case (upc)
            5'd0:    uword = 16'h0021;
            5'd1:    uword = 16'h0100;
            5'd2:    uword = 16'h1000;
            5'd3:    uword = 16'h1144;
            5'd4:    uword = 16'h0200;
            5'd5:    uword = 16'h2000;
            5'd6:    uword = 16'h2267;
            5'd7:    uword = 16'h0300;
            5'd8:    uword = 16'h3000;
            5'd9:    uword = 16'h338A;
            5'd10:   uword = 16'h0400;
            5'd11:   uword = 16'h4000;
            5'd12:   uword = 16'h44AD;
            5'd13:   uword = 16'h0500;
            5'd14:   uword = 16'h5000;
            5'd15:   uword = 16'h55D0;
            5'd16:   uword = 16'h0600;
            5'd17:   uword = 16'h6000;
            5'd18:   uword = 16'h6620;
            // Unused words: output 0x00 and jump straight back to address 0.
            default: uword = 16'h00E0;
        endcase
    end

    assign s_code = uword[15:8];
    assign sel    = uword[7:5];
    assign br     = uword[4:0];

    // Padded so cond[sel] lines up with Condicion<sel>; bits 0 and 7 are
    // never consulted because sel 0 and 7 are handled explicitly below.
    assign cond = {1'b0, Condicion6, Condicion5, Condicion4,
                   Condicion3, Condicion2, Condicion1, 1'b0};

    always_comb begin
        upc_next = upc;
        case (sel)
            3'd0:    upc_next = upc + 5'd1;
            3'd7:    upc_next = br;
            default: begin
                if (cond[sel]) begin
                    upc_next = br;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upc <= 5'd0;
        end else begin
            upc <= upc_next;
        end
    end

    assign {salida7, salida6, salida5, salida4,
            salida3, salida2, salida1, salida0} = s_code;

endmodule

// File: tb/tb_controlador.sv
// tb/tb_controlador.sv - scoreboard bench for the controlador microprogrammed sequencer
module tb_controlador;

    logic       clk;
    logic       rst;
    logic [6:1] c;
    logic [7:0] s;

    int tests_run;
    int tests_failed;

    // Behavioural reference: phase 0 = waiting W_k, 1 = A_k, 2 = B_k; k = 1..7.
    int m_ph;
    int m_k;

    logic [7:0] exp_q[$];

    controlador dut (
        .clk        (clk),
        .rst        (rst),
        .Condicion1 (c[1]),
        .Condicion2 (c[2]),
        .Condicion3 (c[3]),
        .Condicion4 (c[4]),
        .Condicion5 (c[5]),
        .Condicion6 (c[6]),
        .salida0    (s[0]),
        .salida1    (s[1]),
        .salida2    (s[2]),
        .salida3    (s[3]),
        .salida4    (s[4]),
        .salida5    (s[5]),
        .salida6    (s[6]),
        .salida7    (s[7])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_out(input int ph, input int k);
        logic [3:0] n;
        if (ph == 0) begin
            n = 4'(k - 1);
            return {n, n};
        end
        n = 4'(k);
        if (ph == 1) return {4'h0, n};
        return {n, 4'h0};
    endfunction

    task automatic model_reset();
        m_ph = 0;
        m_k  = 1;
    endtask

    task automatic model_advance(input logic [6:1] cv);
        int wait_on;
        case (m_ph)
            0: begin
                wait_on = (m_k == 7) ? 1 : m_k;
                if (cv[wait_on]) begin
                    if (m_k == 7) begin
                        m_k = 1;
                    end else begin
                        m_ph = 1;
                    end
                end
            end
            1: m_ph = 2;
            default: begin
                m_ph = 0;
                m_k  = m_k + 1;
            end
        endcase
    endtask

    task automatic check_pop(input string name);
        logic [7:0] e;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s: scoreboard empty, got S=%02h", name, s);
        end else begin
            e = exp_q.pop_front();
            if (s !== e) begin
                tests_failed++;
                $display("FAIL %s: got S=%02h expected S=%02h", name, s, e);
            end
        end
    endtask

    // One clock: drive conditions at the falling edge, predict, sample 1 ns after the rising edge.
    task automatic step(input logic [6:1] cv, input string name);
        @(negedge clk);
        c = cv;
        model_advance(cv);
        exp_q.push_back(model_out(m_ph, m_k));
        @(posedge clk);
        #1;
        check_pop(name);
    endtask

    task automatic test_reset();
        @(negedge clk);
        c   = 6'b0;
        rst = 1'b0;
        model_reset();
        #1;
        exp_q.push_back(model_out(m_ph, m_k));
        check_pop("reset_immediate");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            exp_q.push_back(model_out(m_ph, m_k));
            check_pop("reset_held");
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) step(6'b0, "idle_after_reset");
    endtask

    task automatic test_stage1();
        for (int i = 0; i < 3; i++) step(6'b000001, "stage1_seq");
        for (int i = 0; i < 4; i++) step(6'b000001, "stage1_hold_c1_high");
    endtask

    task automatic test_wrong_cond();
        for (int i = 0; i < 10; i++) step(6'b111100, "w2_wrong_cond");
        step(6'b000001, "w2_c1_ignored");
    endtask

    task automatic test_chain();
        for (int k = 2; k <= 6; k++) begin
            logic [6:1] cv;
            cv = 6'b0;
            cv[k] = 1'b1;
            step(cv, "chain_wait_edge");
            // Odd stages drop the condition during A_k/B_k, even stages keep it.
            if (k % 2 == 1) cv = 6'b0;
            step(cv, "chain_a_to_b");
            step(cv, "chain_b_to_w");
        end
        for (int i = 0; i < 20; i++) step(6'b0, "w7_hold_idle");
        for (int i = 0; i < 5; i++) step(6'b111110, "w7_hold_other_conds");
    endtask

    task automatic test_restart();
        step(6'b000001, "restart_to_w1");
        step(6'b000001, "restart_to_a1");
        step(6'b000001, "restart_to_b1");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        c   = 6'b0;
        rst = 1'b0;
        model_reset();
        #1;
        exp_q.push_back(model_out(m_ph, m_k));
        check_pop("async_reset_before_edge");
        #2;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) step(6'b0, "after_async_wait_w1");
        step(6'b000001, "after_async_resume");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 25; i++) step(6'b111111, "all_conds_high");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b0;
        c   = 6'b0;
        model_reset();
        test_reset();
        test_stage1();
        test_wrong_cond();
        test_chain();
        test_restart();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
